// File: rtl/vec_serializer_buf.sv
// Frame buffer: captures N_CH parallel words per accept, holds up to FRAMES frames,
// and streams each frame one word per handshake in forward or reversed channel order.
module vec_serializer_buf #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 8,
    parameter int FRAMES = 2,
    localparam int IDX_W = $clog2(N_CH),
    localparam int CNT_W = $clog2(FRAMES + 1)
) (
    input  logic                     clk,
    input  logic                     rsta,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic                     in_rev,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic [CNT_W-1:0]         frame_cnt
);

    localparam int PTR_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam logic [CNT_W-1:0] FRAMES_C = CNT_W'(FRAMES);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(N_CH - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FRAMES - 1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    logic [DATA_W-1:0] r_mem [FRAMES][N_CH];
    logic              r_rev [FRAMES];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [IDX_W-1:0]  r_pos;
    logic [CNT_W-1:0]  r_cnt;
    state_t            r_state;

    logic              w_accept;
    logic              w_hs;
    logic              w_release;
    logic [IDX_W-1:0]  w_eff;
    logic [CNT_W-1:0]  w_cnt_nxt;
    state_t            w_state_nxt;

    // Handshakes are suppressed during flush so nothing is counted in that cycle.
    assign in_ready  = (r_cnt < FRAMES_C);
    assign frame_cnt = r_cnt;
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_hs      = (r_state == S_STREAM) && out_ready && !flush;
    assign w_release = w_hs && (r_pos == LAST_POS);
    assign w_eff     = r_rev[r_rd_ptr] ? (LAST_POS - r_pos) : r_pos;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_accept && !w_release) begin
            w_cnt_nxt = r_cnt + ONE_C;
        end else if (!w_accept && w_release) begin
            w_cnt_nxt = r_cnt - ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < N_CH; k++) begin
                r_mem[r_wr_ptr][k] <= in_data[k*DATA_W +: DATA_W];
            end
            r_rev[r_wr_ptr] <= in_rev;
        end
    end

    always_ff @(posedge clk) begin
        if (rsta || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_pos    <= '0;
            r_cnt    <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_accept) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_release) begin
                r_pos    <= '0;
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end else if (w_hs) begin
                r_pos <= r_pos + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rsta || flush) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        out_data    = '0;
        out_idx     = '0;
        out_last    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                out_valid = 1'b1;
                out_data  = r_mem[r_rd_ptr][w_eff];
                out_idx   = w_eff;
                out_last  = (r_pos == LAST_POS);
                // Stay streaming when another frame is queued or arrives with this release.
                if (w_release && !w_accept && (r_cnt == ONE_C)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vec_serializer_buf.sv
// Directed bench for vec_serializer_buf: default geometry plus a 16x3x1 random-handshake instance.
module tb_vec_serializer_buf;

    logic        clk = 1'b0;
    logic        rsta, flush, in_valid, in_rev, out_ready;
    logic [63:0] in_data;
    logic        in_ready, out_valid, out_last;
    logic [7:0]  out_data;
    logic [2:0]  out_idx;
    logic [1:0]  frame_cnt;

    logic        b_flush, b_in_valid, b_in_rev, b_out_ready;
    logic [47:0] b_in_data;
    logic        b_in_ready, b_out_valid, b_out_last;
    logic [15:0] b_out_data;
    logic [1:0]  b_out_idx;
    logic [0:0]  b_frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  bases3 [3];
    logic [7:0]  bases5 [5];
    int          nf_in, fo, po, mcnt;
    logic        acc, hs, snap_rev;
    logic [47:0] snap_data;
    logic [15:0] q_data [$];
    logic [1:0]  q_idx  [$];
    logic        q_last [$];

    vec_serializer_buf #(.DATA_W(8), .N_CH(8), .FRAMES(2)) u_dut (
        .clk(clk), .rsta(rsta), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rev(in_rev),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .frame_cnt(frame_cnt)
    );

    vec_serializer_buf #(.DATA_W(16), .N_CH(3), .FRAMES(1)) u_dut_b (
        .clk(clk), .rsta(rsta), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_rev(b_in_rev),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_idx(b_out_idx), .out_last(b_out_last), .frame_cnt(b_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack8(input logic [7:0] base);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = base + 8'(k);
        return r;
    endfunction

    // Expects out_ready=1 and a frame whose first word is already on the output.
    task automatic stream8(input string pfx, input logic [7:0] base, input logic rev);
        for (int k = 0; k < 8; k++) begin
            chk({pfx, "_valid"}, 32'(out_valid), 32'(1));
            chk({pfx, "_data"}, 32'(out_data), 32'(base + 8'(rev ? 7 - k : k)));
            chk({pfx, "_idx"}, 32'(out_idx), 32'(rev ? 7 - k : k));
            chk({pfx, "_last"}, 32'(out_last), 32'(k == 7));
            step();
        end
    endtask

    initial begin
        bases3 = '{8'hA0, 8'hB0, 8'hC0};
        bases5 = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        rsta = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rev = 1'b0; out_ready = 1'b0;
        in_data = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_rev = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
        step(); step();
        rsta = 1'b0;
        step();

        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_idx", 32'(out_idx), 32'(0));
        chk("rst_out_last", 32'(out_last), 32'(0));
        chk("rst_frame_cnt", 32'(frame_cnt), 32'(0));

        // Forward order
        out_ready = 1'b1; in_valid = 1'b1; in_data = pack8(8'h10); in_rev = 1'b0;
        step();
        in_valid = 1'b0; in_data = '0;
        chk("fwd_cnt", 32'(frame_cnt), 32'(1));
        stream8("fwd", 8'h10, 1'b0);
        chk("fwd_end_valid", 32'(out_valid), 32'(0));
        chk("fwd_end_cnt", 32'(frame_cnt), 32'(0));
        chk("fwd_end_data", 32'(out_data), 32'(0));

        // Reverse order
        in_valid = 1'b1; in_data = pack8(8'h10); in_rev = 1'b1;
        step();
        in_valid = 1'b0; in_rev = 1'b0; in_data = '0;
        stream8("rev", 8'h10, 1'b1);
        chk("rev_end_valid", 32'(out_valid), 32'(0));

        // Full and backpressure: A, B fill both slots, C waits
        out_ready = 1'b0; in_valid = 1'b1; in_data = pack8(8'hA0);
        step();
        in_data = pack8(8'hB0);
        step();
        in_data = pack8(8'hC0);
        chk("full_cnt", 32'(frame_cnt), 32'(2));
        chk("full_in_ready", 32'(in_ready), 32'(0));
        chk("full_data", 32'(out_data), 32'(8'hA0));
        step(); step();
        chk("hold_cnt", 32'(frame_cnt), 32'(2));
        chk("hold_data", 32'(out_data), 32'(8'hA0));
        chk("hold_idx", 32'(out_idx), 32'(0));
        chk("hold_valid", 32'(out_valid), 32'(1));
        out_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            chk("bp_valid", 32'(out_valid), 32'(1));
            chk("bp_data", 32'(out_data), 32'(bases3[k / 8] + 8'(k % 8)));
            chk("bp_idx", 32'(out_idx), 32'(k % 8));
            chk("bp_last", 32'(out_last), 32'((k % 8) == 7));
            chk("bp_in_ready", 32'(in_ready), 32'((k == 8) || (k >= 16)));
            chk("bp_cnt", 32'(frame_cnt), 32'((k < 8 || (k > 8 && k < 16)) ? 2 : 1));
            step();
            if (k == 8) begin
                in_valid = 1'b0; in_data = '0;
            end
        end
        chk("bp_end_valid", 32'(out_valid), 32'(0));
        chk("bp_end_cnt", 32'(frame_cnt), 32'(0));

        // Accept coinciding with the last-word handshake
        in_valid = 1'b1; in_data = pack8(8'h30);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) step();
        chk("sim_last", 32'(out_last), 32'(1));
        chk("sim_cnt_before", 32'(frame_cnt), 32'(1));
        in_valid = 1'b1; in_data = pack8(8'hE0);
        step();
        in_valid = 1'b0; in_data = '0;
        chk("sim_cnt_after", 32'(frame_cnt), 32'(1));
        stream8("sim", 8'hE0, 1'b0);
        chk("sim_end_valid", 32'(out_valid), 32'(0));

        // Five frames across pointer wrap, alternating order
        nf_in = 0; fo = 0; po = 0;
        for (int c = 0; c < 200 && fo < 5; c++) begin
            in_valid = (nf_in < 5);
            in_data  = (nf_in < 5) ? pack8(bases5[nf_in]) : '0;
            in_rev   = nf_in[0];
            chk("wrap_valid", 32'(out_valid), 32'(nf_in != fo));
            if (out_valid) begin
                chk("wrap_data", 32'(out_data), 32'(bases5[fo] + 8'(fo[0] ? 7 - po : po)));
                chk("wrap_idx", 32'(out_idx), 32'(fo[0] ? 7 - po : po));
                chk("wrap_last", 32'(out_last), 32'(po == 7));
            end
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            step();
            if (acc) nf_in++;
            if (hs) begin
                if (po == 7) begin
                    po = 0; fo++;
                end else begin
                    po++;
                end
            end
        end
        in_valid = 1'b0; in_rev = 1'b0; in_data = '0;
        chk("wrap_frames", 32'(fo), 32'(5));
        chk("wrap_end_valid", 32'(out_valid), 32'(0));

        // Flush and reset mid-frame with a two-frame backlog
        for (int pass = 0; pass < 2; pass++) begin
            out_ready = 1'b0; in_valid = 1'b1; in_data = pack8(8'h70);
            step();
            in_data = pack8(8'h80);
            step();
            in_valid = 1'b0; out_ready = 1'b1;
            step(); step(); step();
            chk("mid_data", 32'(out_data), 32'(8'h73));
            chk("mid_idx", 32'(out_idx), 32'(3));
            in_valid = 1'b1; in_data = pack8(8'hD0);
            if (pass == 0) flush = 1'b1; else rsta = 1'b1;
            step();
            flush = 1'b0; rsta = 1'b0; in_valid = 1'b0; in_data = '0;
            chk("clr_valid", 32'(out_valid), 32'(0));
            chk("clr_cnt", 32'(frame_cnt), 32'(0));
            chk("clr_in_ready", 32'(in_ready), 32'(1));
            chk("clr_data", 32'(out_data), 32'(0));
            in_valid = 1'b1; in_data = pack8(8'h90);
            step();
            in_valid = 1'b0; in_data = '0;
            chk("clr_new_cnt", 32'(frame_cnt), 32'(1));
            stream8("clr_new", 8'h90, 1'b0);
            chk("clr_end_valid", 32'(out_valid), 32'(0));
            chk("clr_end_cnt", 32'(frame_cnt), 32'(0));
        end

        // 16-bit, 3-channel, single-slot instance against a queue model
        mcnt = 0;
        for (int c = 0; c < 420; c++) begin
            b_in_valid  = (c < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
            b_out_ready = (c < 400) ? 1'($urandom_range(0, 1)) : 1'b1;
            b_in_rev    = 1'($urandom_range(0, 1));
            b_in_data   = {16'($urandom), 16'($urandom), 16'($urandom)};
            chk("sw_valid", 32'(b_out_valid), 32'(q_data.size() != 0));
            chk("sw_in_ready", 32'(b_in_ready), 32'(mcnt == 0));
            chk("sw_cnt", 32'(b_frame_cnt), 32'(mcnt));
            if (q_data.size() != 0) begin
                chk("sw_data", 32'(b_out_data), 32'(q_data[0]));
                chk("sw_idx", 32'(b_out_idx), 32'(q_idx[0]));
                chk("sw_last", 32'(b_out_last), 32'(q_last[0]));
            end else begin
                chk("sw_idle_data", 32'(b_out_data), 32'(0));
            end
            acc       = b_in_valid && (mcnt == 0);
            hs        = (q_data.size() != 0) && b_out_ready;
            snap_data = b_in_data;
            snap_rev  = b_in_rev;
            step();
            if (hs) begin
                if (q_last[0]) mcnt--;
                void'(q_data.pop_front());
                void'(q_idx.pop_front());
                void'(q_last.pop_front());
            end
            if (acc) begin
                for (int j = 0; j < 3; j++) begin
                    q_data.push_back(snap_data[(snap_rev ? 2 - j : j)*16 +: 16]);
                    q_idx.push_back(2'(snap_rev ? 2 - j : j));
                    q_last.push_back(j == 2);
                end
                mcnt++;
            end
        end
        b_in_valid = 1'b0;
        chk("sw_drained", 32'(q_data.size()), 32'(0));
        chk("sw_end_valid", 32'(b_out_valid), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_serializer_buf.md
# vec_serializer_buf

Parametrised parallel-in/serial-out frame buffer for the CNN datapath. It captures a frame of N_CH words in one cycle and buffers up to FRAMES frames. Each frame is streamed out one word per handshake, in forward or reversed channel order. It is the next generation of the fixed 8-byte load-then-readback block: width, channel count and depth are parametric, and it adds valid/ready backpressure on both sides, back-to-back frames with no bubble, per-frame order reversal and a flush.

## Interface
- DATA_W, 8, word width in bits (≥1)
- N_CH, 8, words per frame (≥2)
- FRAMES, 2, frame slots buffered (≥1)
- IDX_W, clog2(N_CH), derived localparam, not overridable
- CNT_W, clog2(FRAMES+1), derived localparam
- clk  in  1  single clock, all logic on rising edge
- rsta  in  1  reset, synchronous, active-high
- flush  in  1  synchronous discard of all buffered frames
- in_valid  in  1  frame offered
- in_ready  out  1  slot free; frame accepted when in_valid && in_ready
- in_data  in  N_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- in_rev  in  1  captured with frame; 1 = stream channel N_CH-1 first
- out_valid  out  1  word present
- out_ready  in  1  word consumed when out_valid && out_ready
- out_data  out  DATA_W  current word; forced 0 when out_valid=0
- out_idx  out  IDX_W  channel index of current word; 0 when out_valid=0
- out_last  out  1  current word is last of its frame
- frame_cnt  out  CNT_W  frames held, including the one streaming

## Operation
- Storage: register array of FRAMES×N_CH×DATA_W plus one rev bit per slot. The array is not reset.
- Pointers: wr_ptr and rd_ptr run modulo FRAMES and wrap from FRAMES-1 to 0. word counter pos runs 0..N_CH-1.
- in_ready = (frame_cnt < FRAMES). There is no same-cycle pass-through when full.
- On accept: all N_CH words and in_rev are written to slot wr_ptr, and wr_ptr advances.
- Read state machine:
  - IDLE (frame_cnt=0).
  - STREAM (frame_cnt≠0): out_valid=1; eff = rev ? N_CH-1-pos : pos; out_data = slot[rd_ptr][eff]; out_idx = eff; out_last = (pos==N_CH-1).
- On an output handshake with pos<N_CH-1: pos increments.
- On an output handshake with pos=N_CH-1: pos returns to 0, rd_ptr advances, and the frame is released.
  - If frame_cnt>1, the FSM stays in STREAM and the next frame's first word is presented the following cycle.
  - Otherwise it goes to IDLE.
- frame_cnt update: +1 on accept only; -1 on release only; unchanged on accept and release in the same cycle.
- A release while full makes in_ready=1 only from the next cycle.
- flush=1: next cycle frame_cnt=0, pos=0, wr_ptr=rd_ptr=0, FSM=IDLE. in_valid and out_ready are ignored in the flush cycle, so no accept and no handshake is counted.
- rsta has priority over flush and has the same effect. It is valid mid-frame, and the partially streamed frame is lost.
- out_data/out_valid/out_idx/out_last depend only on registers. There are no combinational input-to-output paths. in_ready is likewise register-only.

## Timing
- Reset values, cycle after rsta: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, frame_cnt=0.
- Latency: frame accepted at edge t → first word visible with out_valid=1 after edge t (cycle t+1).
- Throughput: with out_ready held 1, one word per cycle. Consecutive frames stream with no idle cycle between them.
- With out_ready=0, out_data/out_idx/out_last are held stable.
- out_valid never drops without a handshake, except on flush/rsta.
- in_data is sampled only on the accept edge.

## Test plan
- Basic, forward order (DATA_W=8, N_CH=8, FRAMES=2): after reset, frame words 0x10..0x17 with in_rev=0 and out_ready=1 → out_data 0x10..0x17 on 8 consecutive cycles; out_idx 0..7; out_last only on 0x17; frame_cnt 1→0.
- Reverse order: same frame with in_rev=1 → 0x17..0x10; out_idx 7..0; out_last on 0x10.
- Full and backpressure:
  - Offer frames A, B, C back-to-back with out_ready=0 → A and B accepted, frame_cnt=2, in_ready=0, C held off; out_data stays A0.
  - Raise out_ready → A0..A7 then B0..B7 with no gap. C is accepted the cycle after A7's release.
- Simultaneous events and wrap:
  - Accept a new frame in the same cycle as the last-word handshake → frame_cnt unchanged.
  - Run 5 frames through FRAMES=2 → correct data and order across pointer wrap.
- Flush and reset mid-frame:
  - Flush after 3 words of a 2-frame backlog → next cycle out_valid=0, frame_cnt=0, in_ready=1. A new frame then streams from word 0.
  - Repeat with rsta asserted instead → same result.
- Parameter sweep: DATA_W=16, N_CH=3, FRAMES=1 with random valid/ready → scoreboard matches, in order and with no loss.
